// File: rtl/button_conditioner_if.sv
// Pushbutton bundle between the board pins and the conditioner: raw buttons in,
// clean levels and strobes out.
interface button_conditioner_if #(
  parameter int unsigned NUM_BTN = 5
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] held;
  logic [NUM_BTN-1:0] pressed;
  logic [NUM_BTN-1:0] released;
  logic [NUM_BTN-1:0] repeat_pulse;
  logic [NUM_BTN-1:0] step;

  modport master (
    output btn_raw,
    input  held,
    input  pressed,
    input  released,
    input  repeat_pulse,
    input  step
  );

  modport slave (
    input  btn_raw,
    output held,
    output pressed,
    output released,
    output repeat_pulse,
    output step
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchroniser, debouncer and auto-repeat generator. Every channel is an
// independent copy; all outputs are registered.
module button_conditioner #(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StReleaseDb} state_e;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic [1:0]      sync_q;
    state_e          state_q;
    logic [DbW-1:0]  db_cnt_q;
    logic [RepW-1:0] rep_cnt_q;
    logic            rep_phase_q;  // 0: waiting for first repeat, 1: periodic
    logic [RepW-1:0] rep_target;
    logic            s;
    logic            held_q, pressed_q, released_q, repeat_q, step_q;

    assign s          = sync_q[1];
    assign rep_target = rep_phase_q ? RepW'(REPEAT_PERIOD) : RepW'(REPEAT_DELAY);

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q      <= '0;
        state_q     <= StIdle;
        db_cnt_q    <= '0;
        rep_cnt_q   <= '0;
        rep_phase_q <= 1'b0;
        held_q      <= 1'b0;
        pressed_q   <= 1'b0;
        released_q  <= 1'b0;
        repeat_q    <= 1'b0;
        step_q      <= 1'b0;
      end else begin
        sync_q     <= {sync_q[0], bus.btn_raw[i]};
        pressed_q  <= 1'b0;
        released_q <= 1'b0;
        repeat_q   <= 1'b0;
        step_q     <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (s) begin
              state_q  <= StPressDb;
              db_cnt_q <= DbW'(1);
            end
          end
          StPressDb: begin
            if (!s) begin
              state_q <= StIdle;
            end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES)) begin
              state_q     <= StHeld;
              held_q      <= 1'b1;
              pressed_q   <= 1'b1;
              step_q      <= 1'b1;
              rep_cnt_q   <= '0;
              rep_phase_q <= 1'b0;
            end else begin
              db_cnt_q <= db_cnt_q + DbW'(1);
            end
          end
          StHeld: begin
            if (!s) begin
              state_q  <= StReleaseDb;
              db_cnt_q <= DbW'(1);
            end else if (REPEAT_DELAY != 0) begin
              // Reload on every pulse so the counter never wraps.
              if (rep_cnt_q + RepW'(1) == rep_target) begin
                rep_cnt_q   <= '0;
                rep_phase_q <= 1'b1;
                repeat_q    <= 1'b1;
                step_q      <= 1'b1;
              end else begin
                rep_cnt_q <= rep_cnt_q + RepW'(1);
              end
            end
          end
          StReleaseDb: begin
            if (s) begin
              state_q <= StHeld;
            end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES)) begin
              state_q    <= StIdle;
              held_q     <= 1'b0;
              released_q <= 1'b1;
            end else begin
              db_cnt_q <= db_cnt_q + DbW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign bus.held[i]         = held_q;
    assign bus.pressed[i]      = pressed_q;
    assign bus.released[i]     = released_q;
    assign bus.repeat_pulse[i] = repeat_q;
    assign bus.step[i]         = step_q;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input stage for the board pushbuttons, sitting directly upstream of the counter and display logic. It synchronises each raw button, debounces it, and outputs a clean held level plus single-cycle press, release, auto-repeat and step pulses. Downstream counters consume `step` as an increment/decrement strobe in the fast clock domain. This replaces the practice of using raw buttons or divided clocks as control inputs.

Parameters:
- NUM_BTN, 5, number of independent button channels (up, down, ctr, left, right).
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronised samples needed to accept a level change; must be >= 1.
- REPEAT_DELAY, 50_000_000, cycles in HELD before the first repeat pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat pulses; must be >= 1.

Ports:
- clk, input, 1, system clock (cu_clk at top).
- reset, input, 1, synchronous active-high reset.
- btn_raw, input, NUM_BTN, asynchronous raw buttons, active-high; the top level inverts active-low sources.
- held, output, NUM_BTN, debounced level, 1 while the button is accepted as pressed.
- pressed, output, NUM_BTN, 1-cycle pulse on accepted press.
- released, output, NUM_BTN, 1-cycle pulse on accepted release.
- repeat_pulse, output, NUM_BTN, 1-cycle auto-repeat pulse while held.
- step, output, NUM_BTN, pressed | repeat_pulse.

Behaviour:
- Channels are fully independent and identical. All outputs are registered.
- Reset, sampled on a rising clk edge:
  - Sync flops, counters, all outputs = 0.
  - Every channel enters IDLE.
  - A reset asserted mid-debounce or mid-hold aborts with no pulses.
  - A button still high after reset is re-debounced and produces a fresh `pressed`.
- Synchroniser: 2-flop chain, btn_raw to s. Only s feeds the FSM.
- Per-channel FSM: IDLE, PRESS_DB, HELD, RELEASE_DB. `db_cnt` and `rep_cnt` are sized $clog2(max value + 1).
- IDLE (held = 0): s = 1 → PRESS_DB with db_cnt = 1.
- PRESS_DB (held = 0):
  - s = 0 → IDLE (bounce rejected, no pulse).
  - s = 1 and db_cnt == DEBOUNCE_CYCLES → HELD: pressed = 1 next cycle, held = 1, rep_cnt = 0.
  - Otherwise db_cnt++.
- Press latency: raw high is first sampled at edge k and stays high. `pressed` is high for exactly the cycle following edge k + 2 + DEBOUNCE_CYCLES, and `held` rises at that same edge.
- HELD (held = 1):
  - s = 0 → RELEASE_DB with db_cnt = 1.
  - Otherwise, if REPEAT_DELAY != 0, rep_cnt++.
  - First repeat_pulse fires when rep_cnt reaches REPEAT_DELAY; rep_cnt then reloads so later pulses occur every REPEAT_PERIOD cycles.
  - `pressed` and the first repeat never coincide, because REPEAT_DELAY >= 1 when repeat is enabled.
- RELEASE_DB (held stays 1; rep_cnt frozen, no repeat pulses):
  - s = 1 → HELD, rep_cnt resumes from its frozen value.
  - s = 0 and db_cnt == DEBOUNCE_CYCLES → IDLE: released = 1 next cycle, held = 0.
  - Otherwise db_cnt++.
- Release latency mirrors press latency, measured from the first edge sampling raw low.
- Counters never wrap: db_cnt saturates at DEBOUNCE_CYCLES, and rep_cnt reloads on every pulse.
- Pulse rules:
  - pressed, released and repeat_pulse are mutually exclusive per channel per cycle.
  - step = pressed | repeat_pulse, registered in the same cycle as its source.
- Simultaneous presses on different channels are processed independently with identical timing.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_PERIOD = 8, NUM_BTN = 5.
- Reset: hold reset 3 cycles with btn_raw = 5'b11111 → all outputs 0 during reset. After release, each channel pulses `pressed` exactly 6 edges after the first post-reset sample.
- Clean press and release on btn 0: raw high at edge 10 → pressed[0] high only during the cycle after edge 16, held[0] = 1 from edge 16. Raw low at edge 40 → released[0] after edge 46, held[0] = 0.
- Bounce rejection: btn 1 toggles 1,1,1,0,1,1,1,0 each cycle → no pulses and held[1] stays 0. A subsequent glitch-free press produces exactly one `pressed`.
- Auto-repeat: btn 2 held 60 cycles after acceptance at edge E → repeat_pulse[2] at E+20, E+28, E+36, E+44, E+52. step[2] equals pressed | repeat_pulse throughout.
- Release glitch: btn 3 in HELD drops for 2 cycles then returns → no `released`, held[3] stays 1, and repeat timing shifts by the frozen cycles only.
- Concurrency and reset: btn 0 and btn 4 pressed on the same edge → identical pulse timing on both. Reset asserted mid-HELD → held = 0 with no `released` pulse.
